// File: rtl/ques_two.sv
// Registered 3:1 selector steering D0/D1/I2 onto Out; 1-clock latency.
// No backpressure: the output register loads every cycle while rst is low.
module ques_two #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             S1,
   input  logic             S0,
   input  logic [WIDTH-1:0] D0,
   input  logic [WIDTH-1:0] D1,
   input  logic [WIDTH-1:0] I2,
   output logic [WIDTH-1:0] Out
);

   logic [1:0]       sel;
   logic [WIDTH-1:0] nxt;

   assign sel = {S1, S0};

   // 11 aliases 10; unknown selects also fall through to I2.
   always_comb begin
      nxt = I2;
      case (sel)
         2'b00:   nxt = D0;
         2'b01:   nxt = D1;
         2'b10:   nxt = I2;
         2'b11:   nxt = I2;
         default: nxt = I2;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         Out <= '0;
      end else begin
         Out <= nxt;
      end
   end

endmodule

// File: tb/tb_ques_two.sv
// Scoreboard bench for ques_two: expected values queued at drive, compared after each edge.
module tb_ques_two;
   localparam int W = 4;

   logic         clk;
   logic         rst;
   logic         S1;
   logic         S0;
   logic [W-1:0] D0;
   logic [W-1:0] D1;
   logic [W-1:0] I2;
   logic [W-1:0] Out;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] sb[$];
   logic [W-1:0] last;
   logic [W-1:0] ones;

   ques_two #(.WIDTH(W)) dut (
      .clk(clk),
      .rst(rst),
      .S1(S1),
      .S0(S0),
      .D0(D0),
      .D1(D1),
      .I2(I2),
      .Out(Out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: Out=%h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] model(input logic s1v, input logic s0v,
                                          input logic [W-1:0] d0v, input logic [W-1:0] d1v,
                                          input logic [W-1:0] i2v);
      if (s1v) return i2v;
      else if (s0v) return d1v;
      else return d0v;
   endfunction

   task automatic pop_check(input string tag);
      logic [W-1:0] exp;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL %s: scoreboard empty at %0t", tag, $time);
      end else begin
         exp = sb.pop_front();
         chk(tag, Out, exp);
         last = exp;
      end
   endtask

   // Drive at negedge, confirm Out still holds the prior value, then check after the edge.
   task automatic step(input string tag, input logic s1v, input logic s0v,
                       input logic [W-1:0] d0v, input logic [W-1:0] d1v, input logic [W-1:0] i2v);
      @(negedge clk);
      S1 = s1v; S0 = s0v; D0 = d0v; D1 = d1v; I2 = i2v;
      sb.push_back(model(s1v, s0v, d0v, d1v, i2v));
      #1 chk({tag, "_hold"}, Out, last);
      @(posedge clk);
      #1 pop_check(tag);
   endtask

   initial begin
      ones = '1;
      rst = 1'b1; S1 = 1'b0; S0 = 1'b1; D0 = '0; D1 = ones; I2 = '0;
      last = '0;
      #1 chk("rst_init", Out, '0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1 chk("rst_hold", Out, '0);
      end

      // Release with a select that loads zero, so the first loading edge is checked.
      @(negedge clk);
      S0 = 1'b0; D0 = '0;
      rst = 1'b0;
      sb.push_back('0);
      @(posedge clk);
      #1 pop_check("rel");

      step("sel00_a", 1'b0, 1'b0, '0, ones, '0);
      step("sel00_b", 1'b0, 1'b0, ones, ones, '0);
      step("sel00_c", 1'b0, 1'b0, '0, ones, '0);
      step("sel01", 1'b0, 1'b1, '0, ones, '0);
      step("sel10_a", 1'b1, 1'b0, '0, ones, ones);
      step("sel10_b", 1'b1, 1'b0, '0, ones, '0);
      step("sel11_a", 1'b1, 1'b1, '0, ones, ones);
      step("sel11_b", 1'b1, 1'b1, ones, ones, '0);
      step("sel_mix", 1'b0, 1'b1, 4'h3, 4'hA, 4'h5);
      step("sel_chg", 1'b1, 1'b0, 4'h3, 4'hA, 4'h5);

      // Async reset pulse between edges, inputs keep selecting all-ones.
      step("pre_rst", 1'b0, 1'b1, '0, ones, '0);
      @(negedge clk);
      #1 rst = 1'b1;
      #1 chk("async_rst", Out, '0);
      #1 rst = 1'b0;
      #1 chk("rst_low_gap", Out, '0);
      sb.push_back(ones);
      @(posedge clk);
      #1 pop_check("post_rst");

      // D1 toggles mid-cycle; only the value present at the edge is captured.
      @(negedge clk);
      D1 = '0;
      sb.push_back(4'h6);
      #1 chk("tog_hold1", Out, last);
      D1 = ones;
      #1 chk("tog_hold2", Out, last);
      D1 = 4'h6;
      #1 chk("tog_hold3", Out, last);
      @(posedge clk);
      #1 pop_check("tog_edge");

      for (int i = 0; i < 40; i++) begin
         step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              W'($urandom), W'($urandom), W'($urandom));
      end

      // Reset held across several edges with a non-zero selection.
      @(negedge clk);
      S1 = 1'b0; S0 = 1'b1; D1 = ones;
      rst = 1'b1;
      #1 chk("rst_end0", Out, '0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1 chk("rst_end", Out, '0);
      end

      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
